irq_coalesce: RTL and testbench



---
 rtl/irq_coalesce.sv | 216 +++++++++++++++++++++
 tb/tb_irq_coalesce.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_coalesce.sv
// -----------------------------------------------------------------------------
// irq_coalesce
//
// Interrupt coalescing stage placed after the sticky status register array.
// It counts new masked status events and raises one level interrupt when the
// event count reaches a threshold or when a timeout expires. After software
// acknowledges, it sends a one-cycle clear pulse back to the status registers.
//
// Ports
//   clk         clock
//   rst_n       asynchronous active-low reset
//   status      sticky status vector (dout of the status registers)
//   mask        1 = bit participates in event counting and irq
//   cnt_thresh  events needed to fire; 0 is treated as 1
//   timeout     max ACCUM cycles before firing; 0 disables the timeout
//   irq_ack     acknowledge pulse, honoured only while firing
//   irq         level interrupt (registered)
//   irq_src     masked status captured when the interrupt fired (registered)
//   st_clr      one-cycle clear pulse to the status registers (registered)
//   ev_cnt      current accumulated event count (registered)
// -----------------------------------------------------------------------------
module irq_coalesce #(
   parameter int BITS_W = 8,
   parameter int CNT_W  = 8,
   parameter int TMR_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [BITS_W-1:0] status,
   input  logic [BITS_W-1:0] mask,
   input  logic [CNT_W-1:0]  cnt_thresh,
   input  logic [TMR_W-1:0]  timeout,
   input  logic              irq_ack,
   output logic              irq,
   output logic [BITS_W-1:0] irq_src,
   output logic              st_clr,
   output logic [CNT_W-1:0]  ev_cnt
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_FIRE  = 2'd2,
      ST_CLEAR = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   // Population count of a status vector, clamped to the counter range so a
   // wide vector can never wrap a narrow counter.
   function automatic logic [CNT_W-1:0] sat_popcount(input logic [BITS_W-1:0] v);
      int unsigned n;
      n = 32'd0;
      for (int i = 0; i < BITS_W; i++) begin
         n = n + 32'(v[i]);
      end
      if (n > 32'(CNT_MAX)) begin
         return CNT_MAX;
      end else begin
         return CNT_W'(n);
      end
   endfunction

   // Saturating add of two counter-width values.
   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [CNT_W-1:0] b);
      logic [CNT_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s[CNT_W]) begin
         return CNT_MAX;
      end else begin
         return s[CNT_W-1:0];
      end
   endfunction

   state_t              state_r;
   state_t              state_nxt_s;
   logic [BITS_W-1:0]   m_q_r;
   logic [CNT_W-1:0]    ev_cnt_r;
   logic [CNT_W-1:0]    ev_cnt_nxt_s;
   logic [TMR_W-1:0]    timer_r;
   logic [TMR_W-1:0]    timer_nxt_s;
   logic                irq_r;
   logic                irq_nxt_s;
   logic [BITS_W-1:0]   irq_src_r;
   logic [BITS_W-1:0]   irq_src_nxt_s;
   logic                st_clr_r;
   logic                st_clr_nxt_s;

   logic [BITS_W-1:0]   m_s;
   logic                m_any_s;
   logic [BITS_W-1:0]   rise_s;
   logic [CNT_W-1:0]    thr_s;
   logic [CNT_W-1:0]    pc_m_s;
   logic [CNT_W-1:0]    acc_nxt_s;
   logic [TMR_W:0]      tmr_inc_s;
   logic                timeout_hit_s;

   assign m_s       = status & mask;
   assign m_any_s   = |m_s;
   // A bit counts as a new event in ACCUM only on its 0->1 transition.
   assign rise_s    = m_s & ~m_q_r;
   assign thr_s     = (cnt_thresh == {CNT_W{1'b0}}) ? CNT_ONE : cnt_thresh;
   // IDLE counts every set masked bit, including residue surviving a clear.
   assign pc_m_s    = sat_popcount(m_s);
   assign acc_nxt_s = sat_add(ev_cnt_r, sat_popcount(rise_s));
   // One extra bit keeps timer+1 from wrapping before the compare.
   assign tmr_inc_s     = {1'b0, timer_r} + {{TMR_W{1'b0}}, 1'b1};
   assign timeout_hit_s = (timeout != {TMR_W{1'b0}}) && (tmr_inc_s >= {1'b0, timeout});

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state and next-value logic for the coalescing FSM.
   always_comb begin
      state_nxt_s   = state_r;
      ev_cnt_nxt_s  = ev_cnt_r;
      timer_nxt_s   = timer_r;
      irq_nxt_s     = irq_r;
      irq_src_nxt_s = irq_src_r;
      st_clr_nxt_s  = 1'b0;

      case (state_r)
         ST_IDLE: begin
            if (!m_any_s) begin
               state_nxt_s = ST_IDLE;
            end else if (pc_m_s >= thr_s) begin
               state_nxt_s   = ST_FIRE;
               irq_nxt_s     = 1'b1;
               irq_src_nxt_s = m_s;
               ev_cnt_nxt_s  = pc_m_s;
            end else begin
               state_nxt_s  = ST_ACCUM;
               ev_cnt_nxt_s = pc_m_s;
               timer_nxt_s  = {TMR_W{1'b0}};
            end
         end

         ST_ACCUM: begin
            if (!m_any_s) begin
               // Events withdrawn (mask cleared or status read-cleared).
               state_nxt_s  = ST_IDLE;
               ev_cnt_nxt_s = {CNT_W{1'b0}};
               timer_nxt_s  = {TMR_W{1'b0}};
            end else if ((acc_nxt_s >= thr_s) || timeout_hit_s) begin
               // Threshold and timeout together still produce one fire.
               state_nxt_s   = ST_FIRE;
               irq_nxt_s     = 1'b1;
               irq_src_nxt_s = m_s;
               ev_cnt_nxt_s  = acc_nxt_s;
            end else begin
               state_nxt_s  = ST_ACCUM;
               ev_cnt_nxt_s = acc_nxt_s;
               timer_nxt_s  = tmr_inc_s[TMR_W-1:0];
            end
         end

         ST_FIRE: begin
            if (irq_ack) begin
               state_nxt_s  = ST_CLEAR;
               irq_nxt_s    = 1'b0;
               st_clr_nxt_s = 1'b1;
            end else begin
               state_nxt_s = ST_FIRE;
               irq_nxt_s   = 1'b1;
            end
         end

         ST_CLEAR: begin
            state_nxt_s  = ST_IDLE;
            irq_nxt_s    = 1'b0;
            ev_cnt_nxt_s = {CNT_W{1'b0}};
            timer_nxt_s  = {TMR_W{1'b0}};
         end

         default: begin
            state_nxt_s  = ST_IDLE;
            irq_nxt_s    = 1'b0;
            ev_cnt_nxt_s = {CNT_W{1'b0}};
            timer_nxt_s  = {TMR_W{1'b0}};
         end
      endcase
   end

   // Datapath and output registers; m_q tracks the masked vector every cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_q_r     <= {BITS_W{1'b0}};
         ev_cnt_r  <= {CNT_W{1'b0}};
         timer_r   <= {TMR_W{1'b0}};
         irq_r     <= 1'b0;
         irq_src_r <= {BITS_W{1'b0}};
         st_clr_r  <= 1'b0;
      end else begin
         m_q_r     <= m_s;
         ev_cnt_r  <= ev_cnt_nxt_s;
         timer_r   <= timer_nxt_s;
         irq_r     <= irq_nxt_s;
         irq_src_r <= irq_src_nxt_s;
         st_clr_r  <= st_clr_nxt_s;
      end
   end

   assign irq     = irq_r;
   assign irq_src = irq_src_r;
   assign st_clr  = st_clr_r;
   assign ev_cnt  = ev_cnt_r;

endmodule

// File: tb/tb_irq_coalesce.sv
// -----------------------------------------------------------------------------
// tb_irq_coalesce
//
// Self-checking bench for irq_coalesce. A behavioural model written from the
// coalescing rules predicts irq / irq_src / st_clr / ev_cnt every cycle, and
// hand-computed literal expectations pin the key latencies. The status input
// is produced by a small emulation of the upstream sticky register (set by
// trig, cleared by st_clr, trig wins). A second instance with CNT_W = 2
// exercises counter saturation.
// -----------------------------------------------------------------------------
module tb_irq_coalesce;

   logic        clk;
   logic        rst_n;
   logic [7:0]  status;
   logic [7:0]  mask;
   logic [7:0]  cnt_thresh;
   logic [15:0] timeout;
   logic        irq_ack;
   logic        irq;
   logic [7:0]  irq_src;
   logic        st_clr;
   logic [7:0]  ev_cnt;

   logic [7:0]  s_status;
   logic [7:0]  s_mask;
   logic [1:0]  s_cnt_thresh;
   logic [15:0] s_timeout;
   logic        s_irq_ack;
   logic        s_irq;
   logic [7:0]  s_irq_src;
   logic        s_st_clr;
   logic [1:0]  s_ev_cnt;

   irq_coalesce #(.BITS_W(8), .CNT_W(8), .TMR_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .status(status), .mask(mask),
      .cnt_thresh(cnt_thresh), .timeout(timeout), .irq_ack(irq_ack),
      .irq(irq), .irq_src(irq_src), .st_clr(st_clr), .ev_cnt(ev_cnt)
   );

   irq_coalesce #(.BITS_W(8), .CNT_W(2), .TMR_W(16)) dut_sat (
      .clk(clk), .rst_n(rst_n), .status(s_status), .mask(s_mask),
      .cnt_thresh(s_cnt_thresh), .timeout(s_timeout), .irq_ack(s_irq_ack),
      .irq(s_irq), .irq_src(s_irq_src), .st_clr(s_st_clr), .ev_cnt(s_ev_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Upstream sticky register emulation.
   logic [7:0] trig;
   logic       clr_seen;
   logic       sw_clr;

   // Behavioural model: mode 0 idle, 1 accumulating, 2 firing, 3 clearing.
   int         md;
   int         mcnt;
   int         mtmr;
   logic [7:0] msrc;
   logic [7:0] mprev;
   logic       mirq;
   logic       mclr;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      md = 0; mcnt = 0; mtmr = 0; msrc = 8'h00; mprev = 8'h00;
      mirq = 1'b0; mclr = 1'b0;
   endtask

   function automatic int sat8(input int v);
      return (v > 255) ? 255 : v;
   endfunction

   // One clock of the coalescing rules applied to the current inputs.
   task automatic model_tick();
      logic [7:0] m;
      logic [7:0] newbits;
      int thr;
      int n;
      if (!rst_n) begin
         model_reset();
         return;
      end
      m       = status & mask;
      newbits = m & ~mprev;
      thr     = (cnt_thresh == 8'd0) ? 1 : int'(cnt_thresh);
      mclr    = 1'b0;
      if (md == 0) begin
         if (m != 8'h00) begin
            n = sat8($countones(m));
            if (n >= thr) begin
               md = 2; mirq = 1'b1; msrc = m; mcnt = n;
            end else begin
               md = 1; mcnt = n; mtmr = 0;
            end
         end
      end else if (md == 1) begin
         n = sat8(mcnt + $countones(newbits));
         if (m == 8'h00) begin
            md = 0; mcnt = 0; mtmr = 0;
         end else if (n >= thr || (timeout != 16'd0 && mtmr + 1 >= int'(timeout))) begin
            md = 2; mirq = 1'b1; msrc = m; mcnt = n;
         end else begin
            mcnt = n; mtmr = mtmr + 1;
         end
      end else if (md == 2) begin
         if (irq_ack) begin
            md = 3; mirq = 1'b0; mclr = 1'b1;
         end
      end else begin
         md = 0; mcnt = 0; mtmr = 0;
      end
      mprev = m;
   endtask

   // Advance one cycle: model on the rising edge, compare on the falling edge,
   // then retire pulses and update the emulated sticky status register.
   task automatic step();
      @(posedge clk);
      model_tick();
      @(negedge clk);
      chk("irq",     irq,     mirq);
      chk("irq_src", irq_src, msrc);
      chk("st_clr",  st_clr,  mclr);
      chk("ev_cnt",  ev_cnt,  32'(mcnt));
      irq_ack  = 1'b0;
      status   = ((clr_seen || sw_clr || !rst_n) ? 8'h00 : status) | trig;
      clr_seen = st_clr;
      trig     = 8'h00;
      sw_clr   = 1'b0;
   endtask

   task automatic ack_and_clear();
      irq_ack = 1'b1;
      step();
      chk("ack_irq_low", irq, 32'd0);
      chk("ack_st_clr", st_clr, 32'd1);
      step();
      chk("post_clr_st_clr", st_clr, 32'd0);
      chk("post_clr_ev_cnt", ev_cnt, 32'd0);
   endtask

   initial begin
      rst_n = 1'b0; status = 8'h00; mask = 8'h00; cnt_thresh = 8'd0;
      timeout = 16'd0; irq_ack = 1'b0;
      trig = 8'h00; clr_seen = 1'b0; sw_clr = 1'b0;
      s_status = 8'hFF; s_mask = 8'hFF; s_cnt_thresh = 2'd3;
      s_timeout = 16'd0; s_irq_ack = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);

      // Reset values
      chk("rst_irq", irq, 32'd0);
      chk("rst_irq_src", irq_src, 32'd0);
      chk("rst_st_clr", st_clr, 32'd0);
      chk("rst_ev_cnt", ev_cnt, 32'd0);
      rst_n = 1'b1;
      mask  = 8'hFF;
      step();

      // Saturation: 8 simultaneous events into a 2-bit counter
      chk("sat_ev_cnt", s_ev_cnt, 32'd3);
      chk("sat_irq", s_irq, 32'd1);
      chk("sat_irq_src", s_irq_src, 32'hFF);
      chk("sat_st_clr", s_st_clr, 32'd0);
      step();

      // Immediate fire with threshold 0 (treated as 1)
      cnt_thresh = 8'd0;
      trig = 8'h04;
      step();
      chk("imm_irq_before", irq, 32'd0);
      step();
      chk("imm_irq", irq, 32'd1);
      chk("imm_irq_src", irq_src, 32'h04);
      chk("imm_ev_cnt", ev_cnt, 32'd1);
      repeat (3) step();
      chk("imm_irq_held", irq, 32'd1);
      ack_and_clear();
      step();
      chk("imm_idle_irq", irq, 32'd0);

      // Threshold accumulation: three separate events, thr = 3
      cnt_thresh = 8'd3;
      timeout    = 16'd0;
      trig = 8'h01;
      step();
      step();
      chk("thr_ev1", ev_cnt, 32'd1);
      repeat (2) step();
      trig = 8'h02;
      step();
      step();
      chk("thr_ev2", ev_cnt, 32'd2);
      chk("thr_irq_low", irq, 32'd0);
      repeat (2) step();
      trig = 8'h04;
      step();
      step();
      chk("thr_irq", irq, 32'd1);
      chk("thr_irq_src", irq_src, 32'h07);
      chk("thr_ev3", ev_cnt, 32'd3);
      ack_and_clear();
      step();

      // Timeout: one event, thr = 4, timeout = 5 -> irq timeout+1 cycles later
      cnt_thresh = 8'd4;
      timeout    = 16'd5;
      trig = 8'h10;
      step();
      step();
      chk("to_ev_cnt", ev_cnt, 32'd1);
      repeat (4) step();
      chk("to_irq_early", irq, 32'd0);
      step();
      chk("to_irq", irq, 32'd1);
      chk("to_ev_cnt_fire", ev_cnt, 32'd1);
      chk("to_irq_src", irq_src, 32'h10);
      ack_and_clear();
      step();

      // Masking: unmasked status bits never count
      timeout    = 16'd0;
      cnt_thresh = 8'd1;
      mask = 8'h0F;
      trig = 8'hF0;
      repeat (4) step();
      chk("mask_irq", irq, 32'd0);
      chk("mask_ev_cnt", ev_cnt, 32'd0);
      // Withdrawal: unmask into ACCUM, then drop the mask
      mask = 8'hFF;
      cnt_thresh = 8'd8;
      step();
      chk("wd_accum_ev", ev_cnt, 32'd4);
      mask = 8'h00;
      step();
      chk("wd_ev_cnt", ev_cnt, 32'd0);
      chk("wd_irq", irq, 32'd0);
      sw_clr = 1'b1;
      step();
      mask = 8'hFF;
      step();

      // irq_ack outside FIRE is ignored
      cnt_thresh = 8'd1;
      irq_ack = 1'b1;
      step();
      chk("ack_idle_st_clr", st_clr, 32'd0);
      cnt_thresh = 8'd2;
      trig = 8'h01;
      step();
      step();
      irq_ack = 1'b1;
      step();
      chk("ack_accum_st_clr", st_clr, 32'd0);
      chk("ack_accum_ev", ev_cnt, 32'd1);
      trig = 8'h02;
      step();
      step();
      chk("ec_fire", irq, 32'd1);
      chk("ec_fire_cnt", ev_cnt, 32'd2);

      // Event during CLEAR survives and re-fires two cycles later
      irq_ack = 1'b1;
      step();
      chk("ec_st_clr", st_clr, 32'd1);
      trig = 8'h08;
      cnt_thresh = 8'd1;
      step();
      chk("ec_gap_irq", irq, 32'd0);
      step();
      chk("ec_refire_irq", irq, 32'd1);
      chk("ec_refire_src", irq_src, 32'h08);
      chk("ec_refire_cnt", ev_cnt, 32'd1);
      step();

      // Asynchronous reset while in FIRE
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_irq", irq, 32'd0);
      chk("arst_st_clr", st_clr, 32'd0);
      chk("arst_ev_cnt", ev_cnt, 32'd0);
      chk("arst_irq_src", irq_src, 32'd0);
      model_reset();
      status = 8'h00; trig = 8'h00; clr_seen = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      chk("arst_idle_irq", irq, 32'd0);
      step();
      chk("arst_idle_ev", ev_cnt, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
